// File: rtl/act_pkg.sv
// Shared activation-unit definitions: mode encodings, PLAN segments and breakpoint helpers.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_SIGM = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2,
    ACT_RSVD = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    SEG_LO  = 2'd0,
    SEG_MID = 2'd1,
    SEG_HI  = 2'd2,
    SEG_SAT = 2'd3
  } act_seg_e;

  // 1.0 in Q.f
  function automatic int unsigned act_one(input int unsigned f);
    return 32'd1 << f;
  endfunction

  // 5.0: sigmoid is flat at ONE from here on
  function automatic int unsigned act_bp_sat(input int unsigned f);
    return 32'd5 << f;
  endfunction

  // 2.375 = 19/8
  function automatic int unsigned act_bp_hi(input int unsigned f);
    return 32'd19 << (f - 32'd3);
  endfunction

  // 0.84375 = 27/32
  function automatic int unsigned act_off_hi(input int unsigned f);
    return 32'd27 << (f - 32'd5);
  endfunction

  // 0.625 = 5/8
  function automatic int unsigned act_off_mid(input int unsigned f);
    return 32'd5 << (f - 32'd3);
  endfunction

  // 0.5
  function automatic int unsigned act_off_lo(input int unsigned f);
    return 32'd1 << (f - 32'd1);
  endfunction

  // Round-half-up addend for a right shift by sh (none when sh is 0)
  function automatic int unsigned act_rnd(input int unsigned sh);
    return (sh == 32'd0) ? 32'd0 : (32'd1 << (sh - 32'd1));
  endfunction

  // Reserved encoding behaves as sigmoid
  function automatic act_mode_e act_decode(input logic [1:0] m);
    case (m)
      2'd1:    return ACT_RELU;
      2'd2:    return ACT_HSIG;
      default: return ACT_SIGM;
    endcase
  endfunction

endpackage

// File: rtl/sigm_act_lane.sv
// One activation lane: S1 abs/sign/segment, S2 shift-add, S3 reflect/round/saturate.
module sigm_act_lane
  import act_pkg::*;
#(
  parameter int unsigned IN_W       = 22,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned RELU_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1_i,
  input  logic              en2_i,
  input  logic              en3_i,
  input  act_mode_e         mode1_i,
  input  act_mode_e         mode2_i,
  input  logic [IN_W-1:0]   x_i,
  output logic [OUT_W-1:0]  y_o
);

  localparam int unsigned A_W     = IN_W - 1;
  localparam int unsigned V_W     = IN_W;
  localparam int unsigned H_W     = IN_W + 1;
  localparam int unsigned R_W     = V_W + 1;
  localparam int unsigned SH      = FRAC_W - OUT_W;
  localparam int unsigned ONE     = act_one(FRAC_W);
  localparam int unsigned BP_SAT  = act_bp_sat(FRAC_W);
  localparam int unsigned BP_HI   = act_bp_hi(FRAC_W);
  localparam int unsigned OFF_HI  = act_off_hi(FRAC_W);
  localparam int unsigned OFF_MID = act_off_mid(FRAC_W);
  localparam int unsigned OFF_LO  = act_off_lo(FRAC_W);
  localparam int unsigned RND     = act_rnd(SH);
  localparam int unsigned OMAX    = (32'd1 << OUT_W) - 32'd1;

  logic [IN_W-1:0]  x1_q;
  logic [A_W-1:0]   a1_q, a1_d;
  act_seg_e         seg1_q, seg1_d;
  logic             neg1_q;
  logic [V_W-1:0]   v2_q, v2_d;
  logic             neg2_q;
  logic signed [H_W-1:0] hs;
  logic [V_W-1:0]   y3;
  logic [R_W-1:0]   r3;
  logic [OUT_W-1:0] y3_q, y3_d;

  // S1: saturated magnitude and PLAN segment select
  always_comb begin
    a1_d   = '0;
    seg1_d = SEG_LO;
    if (x_i[IN_W-1]) begin
      if (x_i[A_W-1:0] == '0) a1_d = '1;
      else                    a1_d = A_W'(-x_i);
    end else begin
      a1_d = x_i[A_W-1:0];
    end
    if (a1_d >= A_W'(BP_SAT))     seg1_d = SEG_SAT;
    else if (a1_d >= A_W'(BP_HI)) seg1_d = SEG_HI;
    else if (a1_d >= A_W'(ONE))   seg1_d = SEG_MID;
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q   <= '0;
      a1_q   <= '0;
      seg1_q <= SEG_LO;
      neg1_q <= 1'b0;
    end else if (en1_i) begin
      x1_q   <= x_i;
      a1_q   <= a1_d;
      seg1_q <= seg1_d;
      neg1_q <= x_i[IN_W-1];
    end
  end

  // S2: per-mode shift-add, result is an unsigned magnitude
  always_comb begin
    v2_d = '0;
    hs   = '0;
    case (mode1_i)
      ACT_RELU: v2_d = x1_q[IN_W-1] ? '0 : V_W'(x1_q >> RELU_SHIFT);
      ACT_HSIG: begin
        hs = ($signed({x1_q[IN_W-1], x1_q}) >>> 2) + $signed(H_W'(OFF_LO));
        if (hs[H_W-1])                        v2_d = '0;
        else if (hs > $signed(H_W'(ONE)))     v2_d = V_W'(ONE);
        else                                  v2_d = V_W'(hs);
      end
      default: begin
        case (seg1_q)
          SEG_SAT: v2_d = V_W'(ONE);
          SEG_HI:  v2_d = V_W'(a1_q >> 5) + V_W'(OFF_HI);
          SEG_MID: v2_d = V_W'(a1_q >> 3) + V_W'(OFF_MID);
          default: v2_d = V_W'(a1_q >> 2) + V_W'(OFF_LO);
        endcase
      end
    endcase
  end

  // S2 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= '0;
      neg2_q <= 1'b0;
    end else if (en2_i) begin
      v2_q   <= v2_d;
      neg2_q <= neg1_q;
    end
  end

  // S3: reflect negative sigmoid, rescale with round-half-up, saturate
  always_comb begin
    y3 = v2_q;
    if (mode2_i == ACT_SIGM && neg2_q) y3 = V_W'(ONE) - v2_q;
    if (mode2_i == ACT_RELU) r3 = {1'b0, y3};
    else                     r3 = ({1'b0, y3} + R_W'(RND)) >> SH;
    y3_d = (r3 > R_W'(OMAX)) ? OUT_W'(OMAX) : r3[OUT_W-1:0];
  end

  // S3 registers drive the lane output
  always_ff @(posedge clk) begin
    if (rst)        y3_q <= '0;
    else if (en3_i) y3_q <= y3_d;
  end

  assign y_o = y3_q;

endmodule

// File: rtl/sigm_act_pipe.sv
// Multi-lane pipelined activation unit with valid/ready handshake and global stall.
module sigm_act_pipe
  import act_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned IN_W       = 22,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned RELU_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [NCH*IN_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*OUT_W-1:0]  out_data,
  output logic                  busy
);

  logic      v1_q, v2_q, v3_q;
  act_mode_e m1_q, m2_q;
  logic      stall;
  logic      en1, en2, en3;

  // Whole pipe freezes only when the output beat is refused
  assign stall    = v3_q && !out_ready;
  assign in_ready = !stall;
  assign en1      = !stall && in_valid;
  assign en2      = !stall && v1_q;
  assign en3      = !stall && v2_q;

  // Stage valid flags and mode sideband travel with the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      m1_q <= ACT_SIGM;
      m2_q <= ACT_SIGM;
    end else if (!stall) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) m1_q <= act_decode(in_mode);
      if (v1_q)     m2_q <= m1_q;
    end
  end

  assign out_valid = v3_q;
  assign busy      = v1_q | v2_q | v3_q;

  // Per-lane datapaths share the stage enables
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sigm_act_lane #(
      .IN_W       (IN_W),
      .FRAC_W     (FRAC_W),
      .OUT_W      (OUT_W),
      .RELU_SHIFT (RELU_SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en1_i   (en1),
      .en2_i   (en2),
      .en3_i   (en3),
      .mode1_i (m1_q),
      .mode2_i (m2_q),
      .x_i     (in_data[k*IN_W +: IN_W]),
      .y_o     (out_data[k*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_sigm_act_pipe.sv
// Directed bench for sigm_act_pipe: fixed vectors, handshake/stall/reset behaviour, sigmoid sweep.
module tb_sigm_act_pipe;

  localparam int NCH = 4;
  localparam int IN_W = 22;
  localparam int OUT_W = 8;
  localparam int DW = NCH * IN_W;
  localparam int QW = NCH * OUT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sq_d[$];
  logic [1:0]    sq_m[$];
  logic [QW-1:0] eq[$];
  logic [QW-1:0] got[$];

  logic [DW-1:0] b0, b1, b2, d;
  logic [QW-1:0] e0, e1, e2;
  logic [QW-1:0] w_prev, w_cur;
  int            x, p, c;

  sigm_act_pipe #(
    .NCH(4), .IN_W(22), .FRAC_W(8), .OUT_W(8), .RELU_SHIFT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] pack_in(input int a0, input int a1, input int a2, input int a3);
    logic [DW-1:0] v;
    v[0*IN_W +: IN_W] = IN_W'(a0);
    v[1*IN_W +: IN_W] = IN_W'(a1);
    v[2*IN_W +: IN_W] = IN_W'(a2);
    v[3*IN_W +: IN_W] = IN_W'(a3);
    return v;
  endfunction

  function automatic logic [QW-1:0] pack_out(input int a0, input int a1, input int a2, input int a3);
    logic [QW-1:0] v;
    v[0*OUT_W +: OUT_W] = OUT_W'(a0);
    v[1*OUT_W +: OUT_W] = OUT_W'(a1);
    v[2*OUT_W +: OUT_W] = OUT_W'(a2);
    v[3*OUT_W +: OUT_W] = OUT_W'(a3);
    return v;
  endfunction

  // Reference activation in plain integer arithmetic (ONE = 256, no rescale needed)
  function automatic int ref_lane(input int xv, input int mode);
    int a, y;
    if (mode == 1) begin
      y = (xv < 0) ? 0 : (xv >>> 4);
      return (y > 255) ? 255 : y;
    end
    if (mode == 2) begin
      y = (xv >>> 2) + 128;
      if (y < 0)   y = 0;
      if (y > 256) y = 256;
      return (y > 255) ? 255 : y;
    end
    a = (xv < 0) ? -xv : xv;
    if (a > 2097151) a = 2097151;
    if (a >= 1280)     y = 256;
    else if (a >= 608) y = a / 32 + 216;
    else if (a >= 256) y = a / 8 + 160;
    else               y = a / 4 + 128;
    if (xv < 0) y = 256 - y;
    return (y > 255) ? 255 : y;
  endfunction

  function automatic logic [QW-1:0] ref_beat(input logic [DW-1:0] dv, input int mode);
    logic [QW-1:0] r;
    logic signed [IN_W-1:0] xs;
    for (int k = 0; k < NCH; k++) begin
      xs = dv[k*IN_W +: IN_W];
      r[k*OUT_W +: OUT_W] = OUT_W'(ref_lane(int'(xs), mode));
    end
    return r;
  endfunction

  task automatic push_beat(input logic [DW-1:0] dv, input logic [1:0] m, input logic [QW-1:0] e);
    sq_d.push_back(dv);
    sq_m.push_back(m);
    eq.push_back(e);
  endtask

  task automatic drive_next(input bit rnd);
    if (sq_d.size() > 0) begin
      in_valid = 1'b1;
      in_data  = sq_d[0];
      in_mode  = sq_m[0];
    end else begin
      in_valid = 1'b0;
    end
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Feed queued beats, check outputs in order and hold-stability under stall
  task automatic run_stream(input string tag, input bit rnd);
    int cyc;
    bit held;
    logic [QW-1:0] hd;
    cyc  = 0;
    held = 1'b0;
    hd   = '0;
    drive_next(rnd);
    while ((sq_d.size() > 0 || eq.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      if (held) begin
        chk({tag, " hold valid"}, 64'(out_valid), 64'(1));
        chk({tag, " hold data"}, 64'(out_data), 64'(hd));
      end
      held = out_valid && !out_ready;
      hd   = out_data;
      if (out_valid && out_ready) begin
        if (eq.size() == 0) chk({tag, " extra beat"}, 64'(out_valid), 64'(0));
        else begin
          chk(tag, 64'(out_data), 64'(eq.pop_front()));
          got.push_back(out_data);
        end
      end
      if (in_valid && in_ready) begin
        void'(sq_d.pop_front());
        void'(sq_m.pop_front());
      end
      @(posedge clk);
      #1;
      drive_next(rnd);
      cyc++;
    end
    chk({tag, " drained"}, 64'(eq.size()), 64'(0));
    sq_d.delete();
    sq_m.delete();
    eq.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_data = '0; out_ready = 1'b1;
    b0 = pack_in(0, 256, -256, 16640);      e0 = pack_out(128, 192, 64, 255);
    b1 = pack_in(512, -100, 16640, 15);     e1 = pack_out(32, 0, 255, 0);
    b2 = pack_in(256, 1024, -1024, 0);      e2 = pack_out(192, 255, 0, 128);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'(1));

    // 1: sigmoid basic with exact 3-cycle latency
    in_data = b0; in_mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1 lat1 out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("t1 lat2 out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("t1 lat3 out_valid", 64'(out_valid), 64'(1));
    chk("t1 data", 64'(out_data), 64'(e0));
    @(posedge clk); #1;
    chk("t1 consumed", 64'(out_valid), 64'(0));

    // 2: sigmoid segment edges, saturation, most-negative input
    push_beat(pack_in(-16640, 608, 1280, -2097152), 2'd0, pack_out(0, 235, 255, 0));
    // 3: ReLU and hard-sigmoid, plus reserved mode acting as sigmoid
    push_beat(b1, 2'd1, e1);
    push_beat(b2, 2'd2, e2);
    push_beat(b0, 2'd3, e0);
    run_stream("t2t3", 1'b0);

    // 4: mixed-mode stream under random backpressure
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NCH; k++) d[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 40000)) - 20000);
      if (i % 5 == 4) d[0 +: IN_W] = IN_W'($urandom);
      push_beat(d, 2'(i % 4), ref_beat(d, i % 4));
    end
    run_stream("t4", 1'b1);

    // 5: fill under backpressure, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = b0; in_mode = 2'd0;
    @(posedge clk); #1;
    in_data = b1; in_mode = 2'd1;
    @(posedge clk); #1;
    in_data = b2; in_mode = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5 in_ready stalled", 64'(in_ready), 64'(0));
    chk("t5 busy stalled", 64'(busy), 64'(1));
    chk("t5 out_valid stalled", 64'(out_valid), 64'(1));
    chk("t5 data0", 64'(out_data), 64'(e0));
    @(posedge clk); #1;
    chk("t5 data0 held", 64'(out_data), 64'(e0));
    chk("t5 in_ready held", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5 drain1 valid", 64'(out_valid), 64'(1));
    chk("t5 drain1 data", 64'(out_data), 64'(e1));
    @(posedge clk); #1;
    chk("t5 drain2 data", 64'(out_data), 64'(e2));
    chk("t5 drain2 busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk("t5 empty valid", 64'(out_valid), 64'(0));
    chk("t5 empty busy", 64'(busy), 64'(0));

    // 6: reset with two beats in flight discards them
    in_valid = 1'b1; in_data = b0; in_mode = 2'd0;
    @(posedge clk); #1;
    in_data = b1; in_mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6 out_valid", 64'(out_valid), 64'(0));
    chk("t6 out_data", 64'(out_data), 64'(0));
    chk("t6 busy", 64'(busy), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t6 no stale beat", 64'(out_valid), 64'(0));
    end

    // Sigmoid sweep -16640..16640 step 32, model match and monotonicity
    got.delete();
    for (int b = 0; b < 261; b++) begin
      for (int k = 0; k < NCH; k++) begin
        x = -16640 + 32 * (b * NCH + k);
        if (x > 16640) x = 16640;
        d[k*IN_W +: IN_W] = IN_W'(x);
      end
      push_beat(d, 2'd0, ref_beat(d, 0));
    end
    run_stream("sweep", 1'b0);
    chk("sweep beat count", 64'(got.size()), 64'(261));
    for (int j = 1; j < NCH * got.size(); j++) begin
      w_prev = got[(j - 1) / NCH];
      w_cur  = got[j / NCH];
      p = int'(w_prev[((j - 1) % NCH) * OUT_W +: OUT_W]);
      c = int'(w_cur[(j % NCH) * OUT_W +: OUT_W]);
      n_cmp++;
      assert (c >= p) else begin
        n_bad++;
        $error("FAIL sweep monotonic at index %0d: observed %0d required >= %0d", j, c, p);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
